pipe_stage_skid: RTL and testbench

- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one opaque data payload plus a control field that a flush must kill.
- Uses a valid/ready handshake instead of a global stall, with an optional 2-entry skid buffer so `in_ready` is registered.
- Maintains saturating per-stage performance counters for stalls, flushes and transfers.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_skid_sat_counter.sv | 24 ++
 rtl/pipe_stage_skid.sv | 119 +++++++++++
 tb/tb_pipe_stage_skid.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: FSM states, default widths
// and the saturating increment used by the statistics counters.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam bit          DEF_SKID   = 1'b1;

  // Increment v, but stick at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= mx) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register: valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), flush that kills all held entries, and stats.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter bit          SKID   = DEF_SKID,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              rdy_q;
  logic              accept, take;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign take      = out_valid & out_ready;
  assign in_ready  = SKID ? rdy_q : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !take)      state_nx = SKID ? TWO : ONE;
        else if (!accept && take) state_nx = EMPTY;
      end
      TWO:     if (take) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      rdy_q     <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx != TWO);
      if (flush) begin
        main_data <= '0;
        main_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else if (accept && (state == EMPTY || take)) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (accept) begin
        // ONE without take: new beat queues behind main
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (state == TWO && take) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .clr (clr_stats),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (clr_stats),
    .cnt (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_xfer (
    .clk (clk),
    .rst (rst),
    .inc (take),
    .clr (clr_stats),
    .cnt (xfer_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations share one stimulus stream and
// are checked every cycle against a FIFO-level model, plus directed literal checks.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        clr_stats = 1'b0;
  logic        chk_on = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // index 0: SKID=1 CNT_W=16, index 1: SKID=0 CNT_W=16, index 2: SKID=1 CNT_W=4
  logic        d_ir[3], d_ov[3];
  logic [63:0] d_data[3];
  logic [7:0]  d_ctrl[3];
  logic [1:0]  d_occ[3];
  logic [15:0] s_a, f_a, x_a, s_b, f_b, x_b;
  logic [3:0]  s_c, f_c, x_c;
  logic [63:0] d_st[3], d_fl[3], d_xf[3];

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(1'b1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d_ov[0]), .out_ready(out_ready),
    .out_data(d_data[0]), .out_ctrl(d_ctrl[0]), .occupancy(d_occ[0]), .clr_stats(clr_stats),
    .stall_cnt(s_a), .flush_cnt(f_a), .xfer_cnt(x_a));

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d_ov[1]), .out_ready(out_ready),
    .out_data(d_data[1]), .out_ctrl(d_ctrl[1]), .occupancy(d_occ[1]), .clr_stats(clr_stats),
    .stall_cnt(s_b), .flush_cnt(f_b), .xfer_cnt(x_b));

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID(1'b1), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(d_ov[2]), .out_ready(out_ready),
    .out_data(d_data[2]), .out_ctrl(d_ctrl[2]), .occupancy(d_occ[2]), .clr_stats(clr_stats),
    .stall_cnt(s_c), .flush_cnt(f_c), .xfer_cnt(x_c));

  assign d_st[0] = 64'(s_a);  assign d_fl[0] = 64'(f_a);  assign d_xf[0] = 64'(x_a);
  assign d_st[1] = 64'(s_b);  assign d_fl[1] = 64'(f_b);  assign d_xf[1] = 64'(x_b);
  assign d_st[2] = 64'(s_c);  assign d_fl[2] = 64'(f_c);  assign d_xf[2] = 64'(x_c);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: each stage is a FIFO of at most 2 beats {ctrl,data}.
  bit          m_skid[3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] m_max[3]  = '{64'hFFFF, 64'hFFFF, 64'hF};
  logic [71:0] m_q[3][2];
  int unsigned m_n[3];
  logic        m_rdy[3];
  logic [63:0] m_st[3], m_fl[3], m_xf[3];

  function automatic logic [63:0] bump(input logic [63:0] v, input logic [63:0] mx);
    return (v < mx) ? v + 64'd1 : v;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_n[i] = 0; m_rdy[i] = 1'b1;
        m_st[i] = '0; m_fl[i] = '0; m_xf[i] = '0;
      end else begin
        logic tk, rdy, acc;
        tk  = (m_n[i] > 0) && out_ready;
        rdy = m_skid[i] ? m_rdy[i] : ((m_n[i] == 0) || out_ready);
        acc = in_valid && rdy && !flush;
        if (clr_stats) begin
          m_st[i] = '0; m_fl[i] = '0; m_xf[i] = '0;
        end else begin
          if (m_n[i] > 0 && !out_ready) m_st[i] = bump(m_st[i], m_max[i]);
          if (flush) m_fl[i] = bump(m_fl[i], m_max[i]);
          if (tk)    m_xf[i] = bump(m_xf[i], m_max[i]);
        end
        if (flush) m_n[i] = 0;
        else begin
          if (tk) begin m_q[i][0] = m_q[i][1]; m_n[i]--; end
          if (acc) begin m_q[i][m_n[i]] = {in_ctrl, in_data}; m_n[i]++; end
        end
        m_rdy[i] = (m_n[i] < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m%0d.out_valid", i), 64'(d_ov[i]), 64'(m_n[i] > 0));
        chk($sformatf("m%0d.occupancy", i), 64'(d_occ[i]), 64'(m_n[i]));
        chk($sformatf("m%0d.in_ready", i), 64'(d_ir[i]),
            64'(m_skid[i] ? m_rdy[i] : ((m_n[i] == 0) || out_ready)));
        if (m_n[i] > 0) begin
          chk($sformatf("m%0d.out_data", i), d_data[i], m_q[i][0][63:0]);
          chk($sformatf("m%0d.out_ctrl", i), 64'(d_ctrl[i]), 64'(m_q[i][0][71:64]));
        end
        chk($sformatf("m%0d.stall_cnt", i), d_st[i], m_st[i]);
        chk($sformatf("m%0d.flush_cnt", i), d_fl[i], m_fl[i]);
        chk($sformatf("m%0d.xfer_cnt", i), d_xf[i], m_xf[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b1;
    chk_on = 1'b1;
    chk("rst.in_ready", 64'(d_ir[0]), 64'd1);
    chk("rst.out_valid", 64'(d_ov[0]), 64'd0);
    chk("rst.occupancy", 64'(d_occ[0]), 64'd0);
    chk("rst.counters", d_st[0] | d_fl[0] | d_xf[0], 64'd0);

    // Single beat, 1-cycle latency
    in_valid = 1'b1; in_data = 64'hA5; in_ctrl = 8'h3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1.out_valid", 64'(d_ov[0]), 64'd1);
    chk("t1.out_data", d_data[0], 64'hA5);
    chk("t1.out_ctrl", 64'(d_ctrl[0]), 64'h3);
    tick();
    chk("t1.xfer_cnt", d_xf[0], 64'd1);

    // Fill skid buffer while stalled, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 8'h1; tick();
    in_data = 64'h22; in_ctrl = 8'h2; tick();
    in_valid = 1'b0;
    chk("t2.occupancy", 64'(d_occ[0]), 64'd2);
    chk("t2.in_ready", 64'(d_ir[0]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2.hold_data", d_data[0], 64'h11);
    end
    out_ready = 1'b1;
    chk("t2.first", d_data[0], 64'h11);
    tick();
    chk("t2.second", d_data[0], 64'h22);
    tick();
    chk("t2.drained", 64'(d_ov[0]), 64'd0);
    chk("t2.stall_cnt", d_st[0], 64'd4);

    // Flush with a full buffer and an incoming beat
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h44; tick();
    in_data = 64'h55; tick();
    chk("t3.full", 64'(d_occ[0]), 64'd2);
    flush = 1'b1; in_data = 64'h33; in_ctrl = 8'h7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3.out_valid", 64'(d_ov[0]), 64'd0);
    chk("t3.out_ctrl", 64'(d_ctrl[0]), 64'd0);
    chk("t3.occupancy", 64'(d_occ[0]), 64'd0);
    chk("t3.flush_cnt", d_fl[0], 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t3.no_33", 64'(d_ov[0]), 64'd0);

    // Continuous in_valid with out_ready toggling
    in_valid = 1'b1;
    for (int k = 0; k < 220; k++) begin
      out_ready = (k % 2 == 0);
      in_data = {$urandom, $urandom}; in_ctrl = 8'($urandom);
      tick();
      if (d_ov[1]) chk("t4.ir_mirror", 64'(d_ir[1]), 64'(out_ready));
    end
    chk("t4.xfer_min", 64'(d_xf[1] >= 64'd100), 64'd1);

    // Random traffic with occasional flush and stats clear
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      clr_stats = ($urandom_range(0, 19) == 0);
      in_data = {$urandom, $urandom}; in_ctrl = 8'($urandom);
      tick();
    end
    flush = 1'b0; clr_stats = 1'b0;

    // 4-bit stall counter saturation, clear beats a concurrent stall
    out_ready = 1'b0; in_valid = 1'b1; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("t5.stall_sat", d_st[2], 64'd15);
    clr_stats = 1'b1; tick();
    clr_stats = 1'b0;
    chk("t5.stall_clr", d_st[2], 64'd0);

    // Asynchronous reset between edges
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 64'h66; tick();
    in_valid = 1'b0;
    chk("t6.occ1", 64'(d_occ[0]), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6.out_valid", 64'(d_ov[0]), 64'd0);
    chk("t6.occupancy", 64'(d_occ[0]), 64'd0);
    chk("t6.counters", d_st[0] | d_fl[0] | d_xf[0], 64'd0);
    tick();
    rst = 1'b1;
    tick(); tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
